ahbl_arbiter: RTL and testbench
===============================

# ahbl_arbiter

AHB-lite N:1 arbiter that shares one downstream AHB-lite slave port, normally the upstream port of the `ahbl_splitter`, among `N_PORTS` masters (hart instruction/data ports, debug). Arbitration is round-robin with zero-cycle latency for an uncontested request. A master that loses arbitration has its address phase captured in a per-master buffer and is stalled via `hready_resp` until the buffered transfer completes downstream. Exclusive-access sideband (`hexcl`/`hmaster`/`hexokay`) is routed with the winning transfer.

## Interface
- `N_PORTS`, 2, number of upstream masters (≥2)
- `W_ADDR`, 32, address width
- `W_DATA`, 32, data width
- `clk` in 1 — clock
- `rst_n` in 1 — reset, asynchronous, active-low
- `src_hready` in N_PORTS — per-master hready (tie to own `src_hready_resp` for true masters)
- `src_hready_resp` out N_PORTS — per-master ready response
- `src_hresp` out N_PORTS — per-master error response
- `src_haddr` in N_PORTS*W_ADDR — address
- `src_hwrite`/`src_htrans`/`src_hsize`/`src_hburst`/`src_hprot`/`src_hmastlock` in N_PORTS*{1,2,3,3,4,1} — address-phase controls
- `src_hwdata` in N_PORTS*W_DATA; `src_hrdata` out N_PORTS*W_DATA — data
- `src_hexcl` in N_PORTS; `src_hmaster` in N_PORTS*8; `src_hexokay` out N_PORTS — exclusive sideband
- `dst_hready` out 1; `dst_hready_resp` in 1; `dst_hresp` in 1
- `dst_haddr`/`dst_hwrite`/`dst_htrans`/`dst_hsize`/`dst_hburst`/`dst_hprot`/`dst_hmastlock` out — single-port address phase
- `dst_hwdata` out W_DATA; `dst_hrdata` in W_DATA
- `dst_hexcl` out 1; `dst_hmaster` out 8; `dst_hexokay` in 1

## Operation
- Request `req[i]` = `buf_valid[i]`, or (`src_htrans[i]` is NONSEQ/SEQ and `src_hready[i]`). Both terms never occur together, because a buffered master is stalled.
- Grant is decided only when `dst_hready_resp`=1. Round-robin starts search at `rr_ptr`. On a grant to i, `rr_ptr` ← (i+1) mod N_PORTS.
- Lock: while the master in the data phase issued with `hmastlock`=1 and requests again, it is re-granted regardless of `rr_ptr`.
- Address mux: the granted master's buffer content is used if `buf_valid`, else its live signals. With no grant, `dst_htrans`=IDLE and other fields are don't-care.
- Buffer capture: `buf_valid[i]` ← 1 and the address-phase fields are latched when live `req[i]` is not granted or `dst_hready_resp`=0. The buffer is cleared on the cycle it is granted with `dst_hready_resp`=1.
- Data-phase owner `mast_d` (one-hot, or zero) ← grant vector when `dst_hready_resp`=1.
- `dst_hwdata`: hwdata of `mast_d`. For a buffered master this is valid because its hwdata is held while it is stalled.
- `dst_hready` = `dst_hready_resp`.
- `src_hrdata[i]` = `dst_hrdata` (broadcast). `src_hresp[i]` = `mast_d[i]` & `dst_hresp`. `src_hexokay[i]` = `mast_d[i]` & `dst_hexokay`.
- `src_hready_resp[i]`:
  - `mast_d[i]`: `dst_hready_resp`
  - else `buf_valid[i]`: 0
  - else a stall register `stall_d[i]` covers the cycle after a buffered grant, until that data phase ends: 0
  - else: 1
- Error: the two-cycle `dst_hresp` sequence is passed through to `mast_d` unchanged. The arbiter does not cancel the buffered requests of other masters.

## Timing
- Reset values:
  - `src_hready_resp`=all 1; `src_hresp`=0; `src_hexokay`=0
  - `dst_htrans`=IDLE; `dst_hexcl`=0; `dst_hmastlock`=0
  - `buf_valid`=0; `mast_d`=0; `rr_ptr`=0
- Uncontested request: appears on `dst_*` in the same cycle (combinational). Data phase follows with no added cycle.
- Losing request: transfer is issued downstream ≥1 cycle later, from the buffer. The loser sees `src_hready_resp`=0 from its data-phase cycle until the downstream data phase of its own transfer completes.
- Simultaneous requests from all N: served in strict `rr_ptr` order. Worst-case wait is N-1 transfers.
- Wrap: `rr_ptr` N_PORTS-1 → 0.
- Downstream wait states (`dst_hready_resp`=0): no grant change, no buffer clear, `mast_d` held.
- Reset mid-transfer clears all state. Pending buffered transfers are discarded.

## Test plan
- Single master: M0 issues NONSEQ read of 0x2000_0000 with downstream ready → `dst_htrans`=NONSEQ the same cycle, `src_hrdata[0]`=slave data next cycle, zero stalls.
- Contention: M0 and M1 issue NONSEQ in the same cycle, `rr_ptr`=0 → M0 granted. M1 buffered, `src_hready_resp[1]`=0 for 1 cycle. M1's transfer issued the next cycle with its captured address. `rr_ptr` ends at 0.
- Fairness: both masters requesting continuously for 8 transfers → grants alternate M0,M1,M0,…, each master completes 4 transfers.
- Wait states: slave holds `dst_hready_resp`=0 for 3 cycles during M1's data phase while M0 requests → M0 buffered. No grant change for 3 cycles, then M0 issued.
- Error: slave returns `hresp`=1 for 2 cycles to M0 → `src_hresp[0]`=1/1, `src_hready_resp[0]`=0 then 1. M1 sees `hresp`=0 throughout.
- Lock and exclusive: M0 issues two transfers with `hmastlock`=1 while M1 requests → both M0 transfers granted back-to-back. `dst_hmaster`/`dst_hexcl` track M0. `dst_hexokay`=1 is reaching `src_hexokay[0]` only.

Source files
------------

// File: rtl/ahbl_arbiter_if.sv
// Bus bundle for the AHB-lite N:1 arbiter: flattened per-master upstream
// ports plus the single shared downstream port. The arbiter takes the
// slave view (it serves the upstream masters); the environment takes master.
interface ahbl_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    // upstream, one slice per master
    logic [N_PORTS-1:0]        src_hready;
    logic [N_PORTS-1:0]        src_hready_resp;
    logic [N_PORTS-1:0]        src_hresp;
    logic [N_PORTS*W_ADDR-1:0] src_haddr;
    logic [N_PORTS-1:0]        src_hwrite;
    logic [N_PORTS*2-1:0]      src_htrans;
    logic [N_PORTS*3-1:0]      src_hsize;
    logic [N_PORTS*3-1:0]      src_hburst;
    logic [N_PORTS*4-1:0]      src_hprot;
    logic [N_PORTS-1:0]        src_hmastlock;
    logic [N_PORTS*W_DATA-1:0] src_hwdata;
    logic [N_PORTS*W_DATA-1:0] src_hrdata;
    logic [N_PORTS-1:0]        src_hexcl;
    logic [N_PORTS*8-1:0]      src_hmaster;
    logic [N_PORTS-1:0]        src_hexokay;

    // downstream, single port
    logic              dst_hready;
    logic              dst_hready_resp;
    logic              dst_hresp;
    logic [W_ADDR-1:0] dst_haddr;
    logic              dst_hwrite;
    logic [1:0]        dst_htrans;
    logic [2:0]        dst_hsize;
    logic [2:0]        dst_hburst;
    logic [3:0]        dst_hprot;
    logic              dst_hmastlock;
    logic [W_DATA-1:0] dst_hwdata;
    logic [W_DATA-1:0] dst_hrdata;
    logic              dst_hexcl;
    logic [7:0]        dst_hmaster;
    logic              dst_hexokay;

    modport slave (
        input  src_hready, src_haddr, src_hwrite, src_htrans, src_hsize,
               src_hburst, src_hprot, src_hmastlock, src_hwdata, src_hexcl,
               src_hmaster,
        output src_hready_resp, src_hresp, src_hrdata, src_hexokay,
        output dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
               dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata, dst_hexcl,
               dst_hmaster,
        input  dst_hready_resp, dst_hresp, dst_hrdata, dst_hexokay
    );

    modport master (
        output src_hready, src_haddr, src_hwrite, src_htrans, src_hsize,
               src_hburst, src_hprot, src_hmastlock, src_hwdata, src_hexcl,
               src_hmaster,
        input  src_hready_resp, src_hresp, src_hrdata, src_hexokay,
        input  dst_hready, dst_haddr, dst_hwrite, dst_htrans, dst_hsize,
               dst_hburst, dst_hprot, dst_hmastlock, dst_hwdata, dst_hexcl,
               dst_hmaster,
        output dst_hready_resp, dst_hresp, dst_hrdata, dst_hexokay
    );
endinterface

// File: rtl/ahbl_arbiter.sv
// AHB-lite N:1 round-robin arbiter. Uncontested requests pass straight
// through in the same cycle; losers are captured in a per-master address
// buffer and stalled until their transfer completes downstream. A master
// holding hmastlock is re-granted while it keeps requesting.
module ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input logic           clk,
    input logic           rst_n,
    ahbl_arbiter_if.slave bus
);
    localparam int         PTR_W       = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;

    logic [N_PORTS-1:0] live_req;
    logic [N_PORTS-1:0] req;
    logic [N_PORTS-1:0] grant;
    logic [N_PORTS-1:0] buf_valid;
    logic [N_PORTS-1:0] mast_d;
    logic [N_PORTS-1:0] stall_d;
    logic               mast_lock;
    logic               lock_hold;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_next;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   hi_idx;
    logic [PTR_W-1:0]   lo_idx;
    logic               hi_hit;

    // captured address phases of masters that lost arbitration
    logic [W_ADDR-1:0]  buf_haddr     [N_PORTS];
    logic [1:0]         buf_htrans    [N_PORTS];
    logic [2:0]         buf_hsize     [N_PORTS];
    logic [2:0]         buf_hburst    [N_PORTS];
    logic [3:0]         buf_hprot     [N_PORTS];
    logic [7:0]         buf_hmaster   [N_PORTS];
    logic [N_PORTS-1:0] buf_hwrite;
    logic [N_PORTS-1:0] buf_hmastlock;
    logic [N_PORTS-1:0] buf_hexcl;

    // live request = active htrans while the master's own hready is high
    always_comb begin
        live_req = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            live_req[i] = bus.src_hready[i] & bus.src_htrans[2*i+1];
        end
        req = live_req | buf_valid;
    end

    // a locked data-phase owner that requests again keeps the bus
    always_comb begin
        lock_hold = mast_lock & (|(mast_d & req));
    end

    // round-robin pick: lowest requester at or above rr_ptr, else lowest overall
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        hi_idx  = '0;
        lo_idx  = '0;
        hi_hit  = 1'b0;
        for (int i = N_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = PTR_W'(i);
            end
            if (req[i] && (PTR_W'(i) >= rr_ptr)) begin
                hi_idx = PTR_W'(i);
                hi_hit = 1'b1;
            end
        end
        if (lock_hold) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (mast_d[i]) begin
                    gnt_idx = PTR_W'(i);
                end
            end
        end else begin
            gnt_idx = hi_hit ? hi_idx : lo_idx;
        end
        // nothing is granted while the downstream slave is inserting wait states
        if (bus.dst_hready_resp && (|req)) begin
            for (int i = 0; i < N_PORTS; i++) begin
                grant[i] = (PTR_W'(i) == gnt_idx);
            end
        end
        rr_next = (gnt_idx == PTR_W'(N_PORTS - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // downstream address phase: buffered copy if present, else live signals
    always_comb begin
        bus.dst_haddr     = '0;
        bus.dst_hwrite    = 1'b0;
        bus.dst_htrans    = HTRANS_IDLE;
        bus.dst_hsize     = '0;
        bus.dst_hburst    = '0;
        bus.dst_hprot     = '0;
        bus.dst_hmastlock = 1'b0;
        bus.dst_hexcl     = 1'b0;
        bus.dst_hmaster   = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                if (buf_valid[i]) begin
                    bus.dst_haddr     = buf_haddr[i];
                    bus.dst_hwrite    = buf_hwrite[i];
                    bus.dst_htrans    = buf_htrans[i];
                    bus.dst_hsize     = buf_hsize[i];
                    bus.dst_hburst    = buf_hburst[i];
                    bus.dst_hprot     = buf_hprot[i];
                    bus.dst_hmastlock = buf_hmastlock[i];
                    bus.dst_hexcl     = buf_hexcl[i];
                    bus.dst_hmaster   = buf_hmaster[i];
                end else begin
                    bus.dst_haddr     = bus.src_haddr[i*W_ADDR +: W_ADDR];
                    bus.dst_hwrite    = bus.src_hwrite[i];
                    bus.dst_htrans    = bus.src_htrans[i*2 +: 2];
                    bus.dst_hsize     = bus.src_hsize[i*3 +: 3];
                    bus.dst_hburst    = bus.src_hburst[i*3 +: 3];
                    bus.dst_hprot     = bus.src_hprot[i*4 +: 4];
                    bus.dst_hmastlock = bus.src_hmastlock[i];
                    bus.dst_hexcl     = bus.src_hexcl[i];
                    bus.dst_hmaster   = bus.src_hmaster[i*8 +: 8];
                end
            end
        end
    end

    // data phase: write data from the owner, responses routed back to it
    always_comb begin
        bus.dst_hwdata      = '0;
        bus.dst_hready      = bus.dst_hready_resp;
        bus.src_hrdata      = {N_PORTS{bus.dst_hrdata}};
        bus.src_hresp       = mast_d & {N_PORTS{bus.dst_hresp}};
        bus.src_hexokay     = mast_d & {N_PORTS{bus.dst_hexokay}};
        bus.src_hready_resp = '1;
        for (int i = 0; i < N_PORTS; i++) begin
            if (mast_d[i]) begin
                bus.dst_hwdata         = bus.src_hwdata[i*W_DATA +: W_DATA];
                bus.src_hready_resp[i] = bus.dst_hready_resp;
            end else if (buf_valid[i] || stall_d[i]) begin
                bus.src_hready_resp[i] = 1'b0;
            end
        end
    end

    // arbitration state; advances only when the downstream data phase completes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid <= '0;
            mast_d    <= '0;
            stall_d   <= '0;
            mast_lock <= 1'b0;
            rr_ptr    <= '0;
        end else begin
            buf_valid <= (buf_valid | live_req) & ~grant;
            if (bus.dst_hready_resp) begin
                mast_d    <= grant;
                stall_d   <= grant & buf_valid;
                mast_lock <= bus.dst_hmastlock;
                if (|grant) begin
                    rr_ptr <= rr_next;
                end
            end
        end
    end

    // capture the address phase of every live request that was not granted
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_PORTS; i++) begin
            if (live_req[i] && !grant[i]) begin
                buf_haddr[i]     <= bus.src_haddr[i*W_ADDR +: W_ADDR];
                buf_hwrite[i]    <= bus.src_hwrite[i];
                buf_htrans[i]    <= bus.src_htrans[i*2 +: 2];
                buf_hsize[i]     <= bus.src_hsize[i*3 +: 3];
                buf_hburst[i]    <= bus.src_hburst[i*3 +: 3];
                buf_hprot[i]     <= bus.src_hprot[i*4 +: 4];
                buf_hmastlock[i] <= bus.src_hmastlock[i];
                buf_hexcl[i]     <= bus.src_hexcl[i];
                buf_hmaster[i]   <= bus.src_hmaster[i*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ahbl_arbiter.sv
// Directed bench for ahbl_arbiter with two masters. Expected downstream
// transfers are queued when stimulus is driven and popped whenever the
// arbiter issues a transfer with the slave ready.
module tb_ahbl_arbiter;
    localparam int N = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ahbl_arbiter_if #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32)) bus ();

    // true masters: hready is their own ready response
    assign bus.src_hready = bus.src_hready_resp;

    ahbl_arbiter #(.N_PORTS(N), .W_ADDR(32), .W_DATA(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [42:0] exp_q [$];
    int nxt [N];
    int cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [31:0] a, input logic wr);
        exp_q.push_back({2'b10, wr, 8'(16 + i), a});
    endtask

    task automatic sb_check();
        logic [42:0] got;
        logic [42:0] want;
        if (bus.dst_hready_resp && bus.dst_htrans[1]) begin
            got = {bus.dst_htrans, bus.dst_hwrite, bus.dst_hmaster, bus.dst_haddr};
            chk("sb_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                want = exp_q.pop_front();
                chk("sb_transfer", 64'(got), 64'(want));
            end
        end
    endtask

    task automatic drv(input int i, input logic act, input logic [31:0] a,
                       input logic wr, input logic lk, input logic ex);
        bus.src_htrans[i*2 +: 2]  = act ? 2'b10 : 2'b00;
        bus.src_haddr[i*32 +: 32] = a;
        bus.src_hwrite[i]         = wr;
        bus.src_hmastlock[i]      = lk;
        bus.src_hexcl[i]          = ex;
    endtask

    task automatic slv(input logic rdy, input logic resp, input logic [31:0] rdata, input logic exok);
        bus.dst_hready_resp = rdy;
        bus.dst_hresp       = resp;
        bus.dst_hrdata      = rdata;
        bus.dst_hexokay     = exok;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
        sb_check();
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.src_htrans    = '0;
        bus.src_haddr     = '0;
        bus.src_hwrite    = '0;
        bus.src_hmastlock = '0;
        bus.src_hexcl     = '0;
        bus.src_hsize     = {3'b010, 3'b010};
        bus.src_hburst    = '0;
        bus.src_hprot     = {4'b0011, 4'b0011};
        bus.src_hmaster   = {8'h11, 8'h10};
        bus.src_hwdata    = {32'h0000_BBBB, 32'hAAAA_0000};
        slv(1'b1, 1'b0, 32'h0, 1'b0);

        // reset values
        step();
        step();
        chk("rst_hready_resp", 64'(bus.src_hready_resp), 64'h3);
        chk("rst_hresp", 64'(bus.src_hresp), 64'h0);
        chk("rst_hexokay", 64'(bus.src_hexokay), 64'h0);
        chk("rst_dst_htrans", 64'(bus.dst_htrans), 64'h0);
        chk("rst_dst_hexcl", 64'(bus.dst_hexcl), 64'h0);
        chk("rst_dst_hmastlock", 64'(bus.dst_hmastlock), 64'h0);
        rst_n = 1'b1;

        // single master, same-cycle pass-through
        step();
        drv(0, 1'b1, 32'h2000_0000, 1'b0, 1'b0, 1'b0);
        push(0, 32'h2000_0000, 1'b0);
        settle();
        chk("single_htrans", 64'(bus.dst_htrans), 64'h2);
        chk("single_no_stall", 64'(bus.src_hready_resp), 64'h3);
        step();
        drv(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b1, 32'h2000_0100, 1'b1, 1'b0, 1'b0);
        push(1, 32'h2000_0100, 1'b1);
        slv(1'b1, 1'b0, 32'hCAFE_0001, 1'b0);
        settle();
        chk("single_rdata", 64'(bus.src_hrdata[31:0]), 64'hCAFE_0001);
        chk("single_rdy_m0", 64'(bus.src_hready_resp[0]), 64'h1);
        step();
        drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        bus.src_hwdata[63:32] = 32'h1111_2222;
        settle();
        chk("wdata_m1", 64'(bus.dst_hwdata), 64'h1111_2222);

        // contention with rr_ptr back at 0 after the wrap
        step();
        drv(0, 1'b1, 32'h3000_0000, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b1, 32'h3000_0004, 1'b0, 1'b0, 1'b0);
        push(0, 32'h3000_0000, 1'b0);
        push(1, 32'h3000_0004, 1'b0);
        settle();
        chk("cont_rdy_addr", 64'(bus.src_hready_resp), 64'h3);
        step();
        drv(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("cont_stall_m1", 64'(bus.src_hready_resp), 64'h1);
        step();
        drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("cont_release", 64'(bus.src_hready_resp), 64'h3);

        // fairness: both masters stream 4 transfers each
        for (int k = 0; k < 4; k++) begin
            push(0, 32'h4000_0000 + 32'(k * 4), 1'b0);
            push(1, 32'h4100_0000 + 32'(k * 4), 1'b0);
        end
        nxt[0] = 0;
        nxt[1] = 0;
        cyc    = 0;
        while ((nxt[0] < 4 || nxt[1] < 4) && cyc < 40) begin
            step();
            for (int i = 0; i < N; i++) begin
                drv(i, nxt[i] < 4, 32'h4000_0000 + 32'(i * 32'h0100_0000) + 32'(nxt[i] * 4),
                    1'b0, 1'b0, 1'b0);
            end
            settle();
            for (int i = 0; i < N; i++) begin
                if (nxt[i] < 4 && bus.src_hready_resp[i]) nxt[i]++;
            end
            cyc++;
        end
        for (int d = 0; d < 3; d++) begin
            step();
            drv(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
            settle();
        end
        chk("fair_m0_count", 64'(nxt[0]), 64'd4);
        chk("fair_m1_count", 64'(nxt[1]), 64'd4);
        chk("fair_drained", 64'(exp_q.size()), 64'd0);

        // downstream wait states during M1's data phase
        step();
        drv(1, 1'b1, 32'h5000_0000, 1'b0, 1'b0, 1'b0);
        push(1, 32'h5000_0000, 1'b0);
        settle();
        step();
        drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drv(0, 1'b1, 32'h5000_0010, 1'b1, 1'b0, 1'b0);
        push(0, 32'h5000_0010, 1'b1);
        slv(1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        chk("ws_idle_1", 64'(bus.dst_htrans), 64'h0);
        chk("ws_rdy_1", 64'(bus.src_hready_resp), 64'h1);
        chk("ws_hready_fwd", 64'(bus.dst_hready), 64'h0);
        for (int w = 2; w <= 3; w++) begin
            step();
            settle();
            chk("ws_idle_n", 64'(bus.dst_htrans), 64'h0);
            chk("ws_rdy_n", 64'(bus.src_hready_resp), 64'h0);
        end
        step();
        slv(1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("ws_issue_rdy", 64'(bus.src_hready_resp), 64'h2);

        // error response to M0 while M1 gets buffered
        step();
        drv(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b1, 32'h5100_0000, 1'b0, 1'b0, 1'b0);
        push(1, 32'h5100_0000, 1'b0);
        slv(1'b0, 1'b1, 32'h0, 1'b0);
        settle();
        chk("err_c1_hresp", 64'(bus.src_hresp), 64'h1);
        chk("err_c1_rdy", 64'(bus.src_hready_resp), 64'h2);
        step();
        slv(1'b1, 1'b1, 32'h0, 1'b0);
        settle();
        chk("err_c2_hresp", 64'(bus.src_hresp), 64'h1);
        chk("err_c2_rdy", 64'(bus.src_hready_resp), 64'h1);
        step();
        drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        slv(1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        chk("err_done_hresp", 64'(bus.src_hresp), 64'h0);
        chk("err_done_rdy", 64'(bus.src_hready_resp), 64'h3);

        // locked + exclusive: M0 keeps the bus for two transfers
        step();
        drv(0, 1'b1, 32'h6000_0000, 1'b0, 1'b1, 1'b1);
        drv(1, 1'b1, 32'h6100_0000, 1'b0, 1'b0, 1'b0);
        push(0, 32'h6000_0000, 1'b0);
        settle();
        chk("lock_hmastlock", 64'(bus.dst_hmastlock), 64'h1);
        chk("lock_hexcl", 64'(bus.dst_hexcl), 64'h1);
        step();
        drv(0, 1'b1, 32'h6000_0004, 1'b0, 1'b1, 1'b0);
        push(0, 32'h6000_0004, 1'b0);
        push(1, 32'h6100_0000, 1'b0);
        slv(1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        chk("excl_okay_m0", 64'(bus.src_hexokay), 64'h1);
        chk("lock_rdy", 64'(bus.src_hready_resp), 64'h1);
        step();
        drv(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        slv(1'b1, 1'b0, 32'h0, 1'b0);
        settle();
        step();
        drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        slv(1'b1, 1'b0, 32'h0, 1'b1);
        settle();
        chk("excl_okay_m1", 64'(bus.src_hexokay), 64'h2);
        slv(1'b1, 1'b0, 32'h0, 1'b0);

        // reset mid-transfer discards the buffered M1 request
        step();
        drv(0, 1'b1, 32'h7000_0000, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b1, 32'h7000_0004, 1'b0, 1'b0, 1'b0);
        push(0, 32'h7000_0000, 1'b0);
        settle();
        step();
        rst_n = 1'b0;
        drv(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("mid_rst_rdy", 64'(bus.src_hready_resp), 64'h3);
        chk("mid_rst_htrans", 64'(bus.dst_htrans), 64'h0);
        step();
        rst_n = 1'b1;
        settle();
        chk("rst_discard", 64'(bus.dst_htrans), 64'h0);
        step();
        drv(0, 1'b1, 32'h7100_0000, 1'b0, 1'b0, 1'b0);
        drv(1, 1'b1, 32'h7100_0004, 1'b0, 1'b0, 1'b0);
        push(0, 32'h7100_0000, 1'b0);
        push(1, 32'h7100_0004, 1'b0);
        settle();
        step();
        drv(0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        step();
        drv(1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        settle();
        chk("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
